// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and address-map defaults for the CPU-side memory access controller.
// The region boundaries must agree with the memory system's address decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_NONE  = 2'd3
  } op_e;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1001_0000;

  // Wide enough for a read latency of up to 15 cycles.
  localparam int unsigned CNT_WIDTH = 4;

  // Store wins over load, load wins over fetch.
  function automatic op_e select_op(input logic fetch, input logic load, input logic store);
    op_e op;
    op = OP_NONE;
    if (store) begin
      op = OP_STORE;
    end else if (load) begin
      op = OP_LOAD;
    end else if (fetch) begin
      op = OP_FETCH;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_region_check.sv
// Combinational legality check of a requested access against the text/data address map.
// Everything below DATA_BASE is read-only as seen from the CPU.
module mem_region_check
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT,
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [1:0]            op_i,
  output logic                  misaligned_o,
  output logic                  store_to_rom_o,
  output logic                  is_ram_o,
  output logic                  is_text_o
);

  localparam logic [ADDR_WIDTH-1:0] TEXT_LO = ADDR_WIDTH'(TEXT_BASE);
  localparam logic [ADDR_WIDTH-1:0] DATA_LO = ADDR_WIDTH'(DATA_BASE);

  logic is_store;

  assign is_store       = (op_i == OP_STORE);
  assign misaligned_o   = (addr_i[1:0] != 2'b00);
  assign is_ram_o       = (addr_i >= DATA_LO);
  assign is_text_o      = (addr_i >= TEXT_LO) && !is_ram_o;
  // The unmapped hole below the text region is rejected for stores as well.
  assign store_to_rom_o = is_store && !is_ram_o;

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the multicycle MIPS memory system: issues fetch/load/store,
// waits the read latency, captures into IR/MDR and reports busy/done/err to the control FSM.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] TEXT_BASE   = TEXT_BASE_DEFAULT,
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req_i,
  input  logic                  load_req_i,
  input  logic                  store_req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_enable_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] mdr_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // The counter reaches zero in the last WAIT cycle, so WAIT lasts WAIT_CYCLES cycles.
  localparam logic [CNT_WIDTH-1:0] WAIT_INIT = CNT_WIDTH'(WAIT_CYCLES - 1);

  state_e                state_q;
  op_e                   op_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic [DATA_WIDTH-1:0] mdr_q;
  logic                  we_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  op_e  req_op_d;
  logic misaligned;
  logic store_to_rom;
  logic is_ram;
  logic is_text;
  logic access_err;

  assign req_op_d   = select_op(fetch_req_i, load_req_i, store_req_i);
  assign access_err = misaligned || store_to_rom;

  mem_region_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TEXT_BASE  (TEXT_BASE),
    .DATA_BASE  (DATA_BASE)
  ) u_region (
    .addr_i         (addr_i),
    .op_i           (req_op_d),
    .misaligned_o   (misaligned),
    .store_to_rom_o (store_to_rom),
    .is_ram_o       (is_ram),
    .is_text_o      (is_text)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FETCH;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      mdr_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_op_d != OP_NONE) begin
            if (access_err) begin
              // Rejected requests complete at once and leave the bus untouched.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              err_q   <= 1'b0;
              op_q    <= req_op_d;
              addr_q  <= addr_i;
              wdata_q <= store_data_i;
              we_q    <= (req_op_d == OP_STORE);
              busy_q  <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          we_q <= 1'b0;
          if (op_q == OP_STORE) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= WAIT_INIT;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            if (op_q == OP_FETCH) begin
              instr_q <= mem_rdata_i;
            end else begin
              mdr_q <= mem_rdata_i;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_address_o      = addr_q;
  assign mem_write_data_o   = wdata_q;
  assign mem_write_enable_o = we_q;
  assign instr_o            = instr_q;
  assign mdr_o              = mdr_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_o              = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (read latency 1 and 3) share the stimulus and are
// checked every cycle against a timestamp-based model, plus a vector table and reset abort.
module tb_mem_access_ctrl;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam int NV = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        load_req = 1'b0;
  logic        store_req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] sdata = '0;
  logic [31:0] rdata = '0;

  logic [31:0] o_addr[2];
  logic [31:0] o_wdata[2];
  logic [31:0] o_instr[2];
  logic [31:0] o_mdr[2];
  logic        o_we[2];
  logic        o_busy[2];
  logic        o_done[2];
  logic        o_err[2];

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset),
    .fetch_req_i(fetch_req), .load_req_i(load_req), .store_req_i(store_req),
    .addr_i(addr), .store_data_i(sdata), .mem_rdata_i(rdata),
    .mem_address_o(o_addr[0]), .mem_write_data_o(o_wdata[0]), .mem_write_enable_o(o_we[0]),
    .instr_o(o_instr[0]), .mdr_o(o_mdr[0]), .busy_o(o_busy[0]), .done_o(o_done[0]), .err_o(o_err[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(reset),
    .fetch_req_i(fetch_req), .load_req_i(load_req), .store_req_i(store_req),
    .addr_i(addr), .store_data_i(sdata), .mem_rdata_i(rdata),
    .mem_address_o(o_addr[1]), .mem_write_data_o(o_wdata[1]), .mem_write_enable_o(o_we[1]),
    .instr_o(o_instr[1]), .mdr_o(o_mdr[1]), .busy_o(o_busy[1]), .done_o(o_done[1]), .err_o(o_err[1])
  );

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  int wait_of[2] = '{1, 3};

  // Model: each accepted request is reduced to the edge numbers at which things happen.
  int          m_acc[2];
  int          m_done[2];
  int          m_free[2];
  int          m_op[2];     // 0 fetch, 1 load, 2 store
  bit          m_active[2];
  bit          m_bad[2];
  logic [31:0] e_addr[2], e_wdata[2], e_instr[2], e_mdr[2];
  logic        e_we[2], e_busy[2], e_done[2], e_err[2];

  typedef struct {
    logic        f, l, s;
    logic [31:0] addr, sdata, rdata;
    logic        exp_err;
    int          lat1, lat3, exp_we;
    logic [31:0] exp_instr, exp_mdr;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_bad[i] = 1'b0; m_free[i] = 0;
      m_acc[i] = 0; m_done[i] = 0; m_op[i] = 0;
      e_addr[i] = '0; e_wdata[i] = '0; e_instr[i] = '0; e_mdr[i] = '0;
      e_we[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0; e_err[i] = 1'b0;
    end
  endfunction

  // Evaluate what each controller does at clock edge e with the inputs currently applied.
  function automatic void model_edge(input int e);
    int op;
    bit bad;
    if (reset !== 1'b1) return;
    for (int i = 0; i < 2; i++) begin
      if (m_active[i] && !m_bad[i] && m_op[i] != 2 && e == m_done[i]) begin
        if (m_op[i] == 0) e_instr[i] = rdata;
        else              e_mdr[i]   = rdata;
      end
      if (e >= m_free[i] && (fetch_req || load_req || store_req)) begin
        op  = store_req ? 2 : (load_req ? 1 : 0);
        bad = (addr[1:0] != 2'b00) || (op == 2 && addr < DATA_BASE);
        m_active[i] = 1'b1; m_acc[i] = e; m_op[i] = op; m_bad[i] = bad;
        e_err[i] = bad;
        if (bad) begin
          m_done[i] = e;
        end else begin
          e_addr[i]  = addr;
          e_wdata[i] = sdata;
          m_done[i]  = (op == 2) ? e + 1 : e + wait_of[i] + 1;
        end
        m_free[i] = m_done[i] + 2;
      end
      e_done[i] = m_active[i] && (e == m_done[i]);
      e_busy[i] = m_active[i] && !m_bad[i] && (e >= m_acc[i]) && (e < m_done[i]);
      e_we[i]   = m_active[i] && !m_bad[i] && (m_op[i] == 2) && (e == m_acc[i]);
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      chk    ($sformatf("w%0d mem_address", wait_of[i]), o_addr[i],  e_addr[i]);
      chk    ($sformatf("w%0d write_data", wait_of[i]),  o_wdata[i], e_wdata[i]);
      chk_bit($sformatf("w%0d write_en", wait_of[i]),    o_we[i],    e_we[i]);
      chk    ($sformatf("w%0d instr", wait_of[i]),       o_instr[i], e_instr[i]);
      chk    ($sformatf("w%0d mdr", wait_of[i]),         o_mdr[i],   e_mdr[i]);
      chk_bit($sformatf("w%0d busy", wait_of[i]),        o_busy[i],  e_busy[i]);
      chk_bit($sformatf("w%0d done", wait_of[i]),        o_done[i],  e_done[i]);
      chk_bit($sformatf("w%0d err", wait_of[i]),         o_err[i],   e_err[i]);
    end
  endtask

  task automatic step();
    edge_no++;
    model_edge(edge_no);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic clear_reqs();
    fetch_req = 1'b0; load_req = 1'b0; store_req = 1'b0;
  endtask

  initial begin
    int seen[2];
    int we_cnt;
    int n_req;
    bit found;

    //              f     l     s     addr          sdata         rdata        err lat1 lat3 we instr         mdr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0040_0004, 32'h0,        32'h2008_0005, 1'b0, 3, 5, 0, 32'h2008_0005, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 2, 1, 32'h2008_0005, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h1001_0002, 32'h0,        32'h1111_1111, 1'b1, 1, 1, 0, 32'h2008_0005, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h1001_0008, 32'h0,        32'hCAFE_0001, 1'b0, 3, 5, 0, 32'h2008_0005, 32'hCAFE_0001};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0040_0010, 32'h5555_0000, 32'h0,        1'b1, 1, 1, 0, 32'h2008_0005, 32'hCAFE_0001};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h1001_0000, 32'h1234_5678, 32'h9999_9999, 1'b0, 2, 2, 1, 32'h2008_0005, 32'hCAFE_0001};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h1001_0004, 32'h0,        32'h0BAD_F00D, 1'b0, 3, 5, 0, 32'h2008_0005, 32'h0BAD_F00D};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 32'h1001_0001, 32'hA5A5_A5A5, 32'h0,        1'b1, 1, 1, 0, 32'h2008_0005, 32'h0BAD_F00D};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h1001_000C, 32'h0,        32'h5555_AAAA, 1'b0, 3, 5, 0, 32'h2008_0005, 32'h5555_AAAA};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'h0F0F_0F0F, 32'h0,        1'b1, 1, 1, 0, 32'h2008_0005, 32'h5555_AAAA};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h1000_FFFC, 32'h7E7E_7E7E, 32'h0,        1'b1, 1, 1, 0, 32'h2008_0005, 32'h5555_AAAA};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0040_0008, 32'h0,        32'h3C01_1001, 1'b0, 3, 5, 0, 32'h3C01_1001, 32'h5555_AAAA};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    #2 reset = 1'b1;
    step();

    // Table-driven transactions
    for (int v = 0; v < NV; v++) begin
      fetch_req = vecs[v].f; load_req = vecs[v].l; store_req = vecs[v].s;
      addr = vecs[v].addr; sdata = vecs[v].sdata; rdata = vecs[v].rdata;
      seen[0] = -1; seen[1] = -1; we_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
        step();
        clear_reqs();
        for (int i = 0; i < 2; i++) if (o_done[i] === 1'b1 && seen[i] < 0) seen[i] = k;
        if (o_we[0] === 1'b1) begin
          we_cnt++;
          chk($sformatf("vec%0d strobe addr", v), o_addr[0], vecs[v].addr);
          chk($sformatf("vec%0d strobe data", v), o_wdata[0], vecs[v].sdata);
        end
        if (seen[0] >= 0 && seen[1] >= 0) break;
      end
      step();
      chk($sformatf("vec%0d latency w1", v), seen[0], vecs[v].lat1);
      chk($sformatf("vec%0d latency w3", v), seen[1], vecs[v].lat3);
      chk($sformatf("vec%0d strobes", v), we_cnt, vecs[v].exp_we);
      chk_bit($sformatf("vec%0d err", v), o_err[0], vecs[v].exp_err);
      chk($sformatf("vec%0d instr", v), o_instr[0], vecs[v].exp_instr);
      chk($sformatf("vec%0d mdr", v), o_mdr[1], vecs[v].exp_mdr);
      $display("vec %0d: f/l/s=%b%b%b addr=%h latency=%0d/%0d err=%b instr=%h mdr=%h",
               v, vecs[v].f, vecs[v].l, vecs[v].s, vecs[v].addr, seen[0], seen[1],
               o_err[0], o_instr[0], o_mdr[0]);
    end

    // Reset asserted while a load sits in WAIT on both instances
    load_req = 1'b1; addr = DATA_BASE + 32'h20; rdata = 32'h7777_0000;
    step();
    clear_reqs();
    step();
    chk_bit("abort busy before reset", o_busy[1], 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step();
    step();
    #2 reset = 1'b1;
    step();
    step();
    chk("post-reset mdr", o_mdr[1], 32'h0);
    $display("reset abort: busy=%b done=%b mdr=%h", o_busy[1], o_done[1], o_mdr[1]);

    // Randomized traffic, checked every cycle against the model
    n_req = 0;
    for (int c = 0; c < 800; c++) begin
      clear_reqs();
      if ($urandom_range(0, 2) == 0) begin
        {fetch_req, load_req, store_req} = 3'($urandom_range(1, 7));
        n_req++;
      end
      case ($urandom_range(0, 5))
        0:       addr = DATA_BASE + {20'h0, 10'($urandom), 2'b00};
        1:       addr = TEXT_BASE + {20'h0, 10'($urandom), 2'b00};
        2:       addr = DATA_BASE + {22'h0, 10'($urandom)};
        3:       addr = $urandom;
        4:       addr = DATA_BASE - 32'd4;
        default: addr = DATA_BASE;
      endcase
      sdata = $urandom;
      rdata = $urandom;
      step();
    end
    clear_reqs();

    // Drain: both instances must settle to idle within a bounded time
    found = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (o_busy[0] === 1'b0 && o_busy[1] === 1'b0 && o_done[0] === 1'b0 && o_done[1] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    chk_bit("drain to idle", found, 1'b1);
    $display("random phase: %0d request cycles applied", n_req);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the memory system in the multicycle MIPS. Accepts fetch/load/store requests from the control unit and drives the memory system's address, write-data and write-enable inputs. Waits a programmable read latency, then captures returned words into the instruction register (fetch) or memory data register (load). Flags misaligned accesses and stores into the text (ROM) region, and holds a busy/done handshake toward the control FSM.

Parameters:
DATA_WIDTH, 32, width of data words
ADDR_WIDTH, 32, width of byte addresses
WAIT_CYCLES, 1, cycles between address presentation and valid read data (1..15)
TEXT_BASE, 32'h0040_0000, lowest address of the ROM/text region
DATA_BASE, 32'h1001_0000, lowest address of the RAM/data region; addresses >= DATA_BASE are RAM, [TEXT_BASE, DATA_BASE) are ROM

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_req_i  in  1  request instruction fetch at addr_i
load_req_i  in  1  request data load at addr_i
store_req_i  in  1  request store of store_data_i at addr_i
addr_i  in  ADDR_WIDTH  byte address of request
store_data_i  in  DATA_WIDTH  store payload
mem_rdata_i  in  DATA_WIDTH  read word from memory system
mem_address_o  out  ADDR_WIDTH  address to memory system
mem_write_data_o  out  DATA_WIDTH  write data to memory system
mem_write_enable_o  out  1  write strobe to memory system
instr_o  out  DATA_WIDTH  instruction register
mdr_o  out  DATA_WIDTH  memory data register
busy_o  out  1  high while a request is in flight
done_o  out  1  one-cycle pulse on completion (including error completion)
err_o  out  1  sticky error: misaligned or store-to-ROM; cleared by next accepted request

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; latched address/data/op cleared; wait counter 0.
- Requests sampled only in IDLE. Priority if several asserted: store > load > fetch. Requests while busy_o=1 are ignored (no queueing).
- IDLE -> ISSUE on accepted request: latch addr, data, op; clear err_o; busy_o=1 next cycle.
- Error check in IDLE on acceptance: addr_i[1:0]!=0 -> misaligned; store with addr_i < DATA_BASE -> store-to-ROM. Either: go to DONE directly, set err_o, no write strobe, IR/MDR unchanged.
- ISSUE (1 cycle): mem_address_o = latched addr; for store, mem_write_enable_o=1 this cycle only, mem_write_data_o = latched data. Store -> DONE. Fetch/load -> WAIT with counter = WAIT_CYCLES-1.
- WAIT: mem_address_o held stable; decrement counter; at 0 capture mem_rdata_i into instr_o (fetch) or mdr_o (load) on that clock edge; -> DONE.
- DONE: done_o=1 for exactly one cycle; busy_o=0 in this cycle; -> IDLE. A request present during DONE is not accepted; accepted next cycle in IDLE.
- Latency (request edge to done_o): store 2 cycles; fetch/load WAIT_CYCLES+2; error 1 cycle.
- mem_address_o holds last value when idle; mem_write_enable_o never high outside ISSUE.
- instr_o and mdr_o hold value until overwritten by a successful fetch/load respectively.
- Reset asserted mid-transaction: immediate abort, outputs to reset values, no partial capture.

Decomposition:
- Package mem_ctrl_pkg: state encoding (IDLE, ISSUE, WAIT, DONE), op encoding (OP_FETCH, OP_LOAD, OP_STORE), TEXT_BASE/DATA_BASE defaults.
- One sub-module natural: mem_region_check (combinational: addr, op -> misaligned, store_to_rom, is_ram); the region boundary is shared with the memory system's address decode.

Test Plan:
- Fetch 0x0040_0004, WAIT_CYCLES=1, mem_rdata_i=0x2008_0005 -> done_o at cycle 3, instr_o=0x2008_0005, mdr_o unchanged, mem_write_enable_o never 1.
- Store 0xDEAD_BEEF to 0x1001_0008 -> single-cycle mem_write_enable_o with address 0x1001_0008, data 0xDEAD_BEEF; done_o 2 cycles after request.
- Load 0x1001_0002 (misaligned) -> err_o=1, done_o next cycle, no strobe, mdr_o unchanged; following valid load clears err_o.
- Store to 0x0040_0010 -> err_o=1, mem_write_enable_o stays 0.
- Simultaneous fetch+store at 0x1001_0000 -> store serviced; fetch ignored; WAIT_CYCLES=3 load then returns done_o at cycle 5.
- reset=0 during WAIT of a load -> all outputs 0 immediately; after release, state IDLE, mdr_o=0.
